// File: rtl/link_monitor_pkg.sv
// link_monitor_pkg: shared state encoding and 50 MHz default timing constants for link_monitor.
package link_monitor_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int DEF_POLL_CYCLES       = 50_000_000;
    localparam int DEF_TIMEOUT_CYCLES    = 1_000_000;
    localparam int DEF_BLINK_HALF_CYCLES = 12_500_000;
endpackage

// File: rtl/led_blinker.sv
// led_blinker: half-period counter and phase register driving the error blink.
module led_blinker
    import link_monitor_pkg::*;
#(
    parameter int HALF_CYCLES = DEF_BLINK_HALF_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic restart,
    output logic phase
);
    localparam int CW = HALF_CYCLES > 1 ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !en && !restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == HALF_LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/link_monitor.sv
// link_monitor: sequences MDIO accesses (key press, pending request, optional poll) and latches link status.
// Define LINK_MONITOR_AUTO_POLL_EN to compile in the periodic poll timer.
module link_monitor
    import link_monitor_pkg::*;
#(
    parameter int POLL_CYCLES       = DEF_POLL_CYCLES,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
    parameter int BLINK_HALF_CYCLES = DEF_BLINK_HALF_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_flag,
    input  logic mdio_set_end_flag,
    input  logic mdio_link_flag,
    output logic mdio_set_start_flag,
    output logic busy,
    output logic link_valid,
    output logic link_up,
    output logic timeout_err,
    output logic led
);
    if (POLL_CYCLES < 2 || TIMEOUT_CYCLES < 2 || BLINK_HALF_CYCLES < 1) begin : g_bad_params
        $error("link_monitor: cycle parameters out of range");
    end
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          pending, poll_hit, done, timed_out, blink;
    assign done      = state == WAIT && mdio_set_end_flag;
    assign timed_out = state == WAIT && !mdio_set_end_flag && wait_cnt == WAIT_LAST;
`ifdef LINK_MONITOR_AUTO_POLL_EN
    localparam int PW = $clog2(POLL_CYCLES);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    logic [PW-1:0] poll_cnt;
    // Counts only uninterrupted idle cycles, so polls are spaced from the last completion.
    always_ff @(posedge sys_clk) begin
        poll_cnt <= sys_rst || state != IDLE || state_nxt != IDLE ? '0 : poll_cnt + PW'(1);
    end
    assign poll_hit = state == IDLE && poll_cnt == POLL_LAST;
`else
    assign poll_hit = 1'b0;
`endif
    always_comb begin
        state_nxt = state == IDLE  ? (key_flag || pending || poll_hit ? ISSUE : IDLE) :
                    state == ISSUE ? WAIT :
                    done || timed_out ? IDLE : WAIT;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            pending     <= 1'b0;
            link_valid  <= 1'b0;
            link_up     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= state == WAIT && state_nxt == WAIT ? wait_cnt + WW'(1) : '0;
            pending  <= state == IDLE ? 1'b0 : pending | key_flag;
            if (done) begin
                link_up     <= mdio_link_flag;
                link_valid  <= 1'b1;
                timeout_err <= 1'b0;
            end else if (timed_out) begin
                link_up     <= 1'b0;
                timeout_err <= 1'b1;
            end
        end
    end
    led_blinker #(.HALF_CYCLES(BLINK_HALF_CYCLES)) u_blinker (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (timeout_err),
        .restart (timed_out),
        .phase   (blink)
    );
    assign mdio_set_start_flag = state == ISSUE;
    assign busy                = state != IDLE;
    assign led                 = timeout_err ? blink : link_valid & link_up;
endmodule

// File: tb/tb_link_monitor.sv
// tb_link_monitor: directed stimulus with a timestamp-based reference model and literal spot checks.
module tb_link_monitor;
    localparam int P = 20;
    localparam int T = 10;
    localparam int H = 4;
`ifdef LINK_MONITOR_AUTO_POLL_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_flag = 1'b0;
    logic mdio_set_end_flag = 1'b0;
    logic mdio_link_flag = 1'b0;
    logic mdio_set_start_flag, busy, link_valid, link_up, timeout_err, led;
    int vectors = 0;
    int miscompares = 0;
    link_monitor #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T), .BLINK_HALF_CYCLES(H)) dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .key_flag            (key_flag),
        .mdio_set_end_flag   (mdio_set_end_flag),
        .mdio_link_flag      (mdio_link_flag),
        .mdio_set_start_flag (mdio_set_start_flag),
        .busy                (busy),
        .link_valid          (link_valid),
        .link_up             (link_up),
        .timeout_err         (timeout_err),
        .led                 (led)
    );
    always #5 sys_clk = ~sys_clk;
    // Reference model: a transaction is described by when it issued, when idle began, when the error rose.
    int  cyc = 0;
    bit  m_on = 0, in_txn = 0, pend = 0, m_valid = 0, m_up = 0, m_err = 0;
    int  issue_at = -1, idle_since = 0, err_at = 0;
    initial begin
        forever begin
            @(posedge sys_clk);
            if (sys_rst) begin
                m_on = 1; in_txn = 0; pend = 0; m_valid = 0; m_up = 0; m_err = 0;
                idle_since = cyc + 1;
            end else if (!in_txn) begin
                if (key_flag || pend || (AUTO && cyc - idle_since == P - 1)) begin
                    in_txn = 1; issue_at = cyc + 1; pend = 0;
                end
            end else begin
                if (key_flag) pend = 1;
                if (cyc != issue_at) begin
                    if (mdio_set_end_flag) begin
                        m_up = mdio_link_flag; m_valid = 1; m_err = 0;
                        in_txn = 0; idle_since = cyc + 1;
                    end else if (cyc - (issue_at + 1) == T - 1) begin
                        m_up = 0; m_err = 1; err_at = cyc + 1;
                        in_txn = 0; idle_since = cyc + 1;
                    end
                end
            end
            cyc++;
        end
    end
    always @(negedge sys_clk) begin
        if (m_on) begin
            logic [5:0] exp_v, act_v;
            logic       led_exp;
            led_exp = m_err ? (((cyc - err_at) / H) % 2 == 0) : (m_valid && m_up);
            exp_v = {in_txn && issue_at == cyc, in_txn, m_valid, m_up, m_err, led_exp};
            act_v = {mdio_set_start_flag, busy, link_valid, link_up, timeout_err, led};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL model cycle %0d {start,busy,valid,up,err,led} got %b expected %b", cyc, act_v, exp_v);
            end
        end
    end
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s got %b expected %b", name, act, exp_v);
        end
    endtask
    task automatic do_reset();
        sys_rst = 1'b1; key_flag = 1'b0; mdio_set_end_flag = 1'b0;
        tick();
        check("reset_outputs", {mdio_set_start_flag, busy, link_valid, link_up, timeout_err, led}, 6'b0);
        sys_rst = 1'b0;
    endtask
    task automatic key();
        key_flag = 1'b1; tick(); key_flag = 1'b0;
    endtask
    task automatic end_flag(input logic link);
        mdio_set_end_flag = 1'b1; mdio_link_flag = link; tick(); mdio_set_end_flag = 1'b0;
    endtask
    initial begin
        int pulses, first, last, gap_bad, prev;
        // Normal access: key at N, end flag with link up at N+4.
        do_reset();
        ticks(2);
        key();
        check("t1_start_pulse", {mdio_set_start_flag, busy}, 6'b11);
        tick();
        check("t1_start_one_cycle", {mdio_set_start_flag, busy}, 6'b01);
        ticks(2);
        end_flag(1'b1);
        check("t1_link_up", {busy, link_valid, link_up, timeout_err, led}, 6'b01101);
        // Timeout, blink, then link-down completion clears the error.
        do_reset();
        key();
        ticks(10);
        check("t2_before_timeout", {busy, timeout_err}, 6'b10);
        tick();
        check("t2_timeout", {busy, link_valid, link_up, timeout_err, led}, 6'b00011);
        ticks(3);
        check("t2_led_still_on", {5'b0, led}, 6'b1);
        tick();
        check("t2_led_off", {5'b0, led}, 6'b0);
        ticks(4);
        check("t2_led_on_again", {5'b0, led}, 6'b1);
        key();
        ticks(2);
        end_flag(1'b0);
        check("t2_recovered", {busy, link_valid, link_up, timeout_err, led}, 6'b01000);
        // Two presses during WAIT collapse into one pending access.
        do_reset();
        key();
        key_flag = 1'b1; tick(); tick(); key_flag = 1'b0;
        tick();
        end_flag(1'b1);
        check("t3_idle_gap", {mdio_set_start_flag, busy}, 6'b00);
        tick();
        check("t3_pending_issue", {mdio_set_start_flag, busy}, 6'b11);
        tick();
        end_flag(1'b0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            pulses += int'(mdio_set_start_flag);
            tick();
        end
        check("t3_no_third_pulse", 6'(pulses), 6'd0);
        // End flag on the final wait cycle wins; stray end flag in IDLE is ignored.
        do_reset();
        key();
        ticks(10);
        check("t4_still_waiting", {busy, timeout_err}, 6'b10);
        end_flag(1'b1);
        check("t4_end_wins", {busy, link_valid, link_up, timeout_err}, 6'b0110);
        end_flag(1'b0);
        check("t4_stray_end", {mdio_set_start_flag, busy, link_valid, link_up, timeout_err, led}, 6'b001101);
        // Reset mid-WAIT, late end flag must not change anything.
        do_reset();
        key();
        ticks(2);
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        tick();
        end_flag(1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t5_quiet_after_reset", {mdio_set_start_flag, busy, link_valid, link_up, timeout_err, led}, 6'b0);
            tick();
        end
        // Idle behaviour: periodic polls spaced P idle cycles after completion, or nothing.
        do_reset();
        pulses = 0; first = -1; last = -1; gap_bad = 0; prev = 0;
        for (int i = 0; i < 200; i++) begin
            mdio_set_end_flag = prev[0]; mdio_link_flag = 1'b1;
            if (mdio_set_start_flag) begin
                if (first < 0) first = i;
                if (last >= 0 && i - last != P + 2) gap_bad++;
                last = i;
                pulses++;
            end
            prev = int'(mdio_set_start_flag);
            tick();
        end
        mdio_set_end_flag = 1'b0;
        if (AUTO) begin
            check("t6_first_poll", 6'(first), 6'(P));
            check("t6_poll_gaps", 6'(gap_bad), 6'd0);
            check("t6_poll_count", 6'(pulses), 6'(200 / (P + 2)));
        end else begin
            check("t6_no_poll", 6'(pulses), 6'd0);
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
